alu_share_arbiter: RTL and testbench

- Sequences the single shared 8-bit add-only ALU between NUM_REQ requesters (e.g. datapath issue, address-offset unit, debug port).
- Each requester presents an operand pair with a valid/ready handshake. The block selects a winner round-robin, drives the ALU operand and ALUOp inputs, and captures the combinational ALU sum into a registered response tagged with the winner id.
- Sits between the requesters and alu_unit; alu_unit stays purely combinational.

---
 rtl/alu_arb_pkg.sv | 12 +
 rtl/alu_share_arbiter_rr.sv | 34 +++
 rtl/alu_share_arbiter.sv | 143 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared state encoding and operand width for the ALU share arbiter
package alu_arb_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// rtl/alu_share_arbiter_rr.sv - combinational round-robin picker (module rr_arbiter)
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    id
);

  always_comb begin : pick
    int              w_idx;
    logic [ID_W-1:0] w_idx_b;
    logic            w_found;
    grant   = '0;
    id      = '0;
    w_idx   = 0;
    w_idx_b = '0;
    w_found = 1'b0;
    // Scan from ptr upward; ptr is always < NUM_REQ so one subtraction wraps it.
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      w_idx_b = ID_W'(w_idx);
      if (!w_found && req[w_idx_b]) begin
        w_found        = 1'b1;
        grant[w_idx_b] = 1'b1;
        id             = w_idx_b;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sequencer for one shared add-only ALU
// Optional flag outputs rsp_carry/rsp_zero exist only when ALU_ARB_FLAGS_EN is defined.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [8*NUM_REQ-1:0]     req_a,
  input  logic [8*NUM_REQ-1:0]     req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [7:0]               alu_a,
  output logic [7:0]               alu_b,
  output logic                     alu_op,
  input  logic [7:0]               alu_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [7:0]               rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     busy
`ifdef ALU_ARB_FLAGS_EN
  ,
  output logic                     rsp_carry,
  output logic                     rsp_zero
`endif
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ALU_W-1:0]    r_op_a;
  logic [ALU_W-1:0]    r_op_b;
  logic [ID_W-1:0]     r_id;
  logic                r_rsp_valid;
  logic [ALU_W-1:0]    r_rsp_data;
  logic [ID_W-1:0]     r_rsp_id;

  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_win_id;
  logic                w_any;
  logic                w_accept;
  logic [ID_W-1:0]     w_ptr_nxt;
  logic [ALU_W-1:0]    w_sel_a;
  logic [ALU_W-1:0]    w_sel_b;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (r_rr_ptr),
    .grant (w_grant),
    .id    (w_win_id)
  );

  assign w_any     = |w_grant;
  assign w_accept  = (r_state == ST_IDLE) && w_any;
  assign w_ptr_nxt = (int'(w_win_id) == NUM_REQ - 1) ? '0 : w_win_id + ID_W'(1);

  // Grant is one-hot, so an OR of masked lanes selects the winner's operands.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a = w_sel_a | req_a[i*ALU_W +: ALU_W];
        w_sel_b = w_sel_b | req_b[i*ALU_W +: ALU_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_any)     w_state_nxt = ST_EXEC;
      ST_EXEC:                w_state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
    end else begin
      if (w_accept) begin
        r_op_a   <= w_sel_a;
        r_op_b   <= w_sel_b;
        r_id     <= w_win_id;
        r_rr_ptr <= w_ptr_nxt;
      end
      if (r_state == ST_EXEC) begin
        r_rsp_data  <= alu_result;
        r_rsp_id    <= r_id;
        r_rsp_valid <= 1'b1;
      end
      if (r_state == ST_RESP && rsp_ready) r_rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_ARB_FLAGS_EN
  logic r_rsp_carry;
  logic r_rsp_zero;

  // An 8-bit add wrapped exactly when the sum is below either addend.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_carry <= 1'b0;
      r_rsp_zero  <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_rsp_carry <= (alu_result < r_op_a);
      r_rsp_zero  <= (alu_result == '0);
    end
  end

  assign rsp_carry = r_rsp_carry;
  assign rsp_zero  = r_rsp_zero;
`endif

  assign req_ready = (r_state == ST_IDLE) ? w_grant : '0;
  assign alu_a     = r_op_a;
  assign alu_b     = r_op_b;
  assign alu_op    = (r_state == ST_EXEC);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_a;
  logic [8*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           alu_a;
  logic [7:0]           alu_b;
  logic                 alu_op;
  logic [7:0]           alu_result;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [7:0]           rsp_data;
  logic [ID_W-1:0]      rsp_id;
  logic                 busy;
`ifdef ALU_ARB_FLAGS_EN
  logic                 rsp_carry;
  logic                 rsp_zero;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  alu_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy)
`ifdef ALU_ARB_FLAGS_EN
    ,
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero)
`endif
  );

  // Stand-in for alu_unit: combinational 8-bit modulo adder.
  assign alu_result = alu_a + alu_b;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int idx, input logic [7:0] a, input logic [7:0] b);
    req_a[idx*8 +: 8] = a;
    req_b[idx*8 +: 8] = b;
  endtask

  logic [7:0] rr_sum [3];

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_busy",      32'(busy),      32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_alu_a",     32'(alu_a),     32'h0);
    check("rst_alu_op",    32'(alu_op),    32'h0);
    check("rst_rsp_data",  32'(rsp_data),  32'h0);
    check("rst_rsp_id",    32'(rsp_id),    32'h0);

    // Single request on requester 0.
    set_op(0, 8'h12, 8'h34);
    req_valid = 3'b001;
    #1;
    check("t1_ready", 32'(req_ready), 32'h1);
    check("t1_busy_idle", 32'(busy), 32'h0);
    tick();
    req_valid = '0;
    #1;
    check("t1_exec_busy",  32'(busy),      32'h1);
    check("t1_exec_op",    32'(alu_op),    32'h1);
    check("t1_exec_a",     32'(alu_a),     32'h12);
    check("t1_exec_b",     32'(alu_b),     32'h34);
    check("t1_exec_rv",    32'(rsp_valid), 32'h0);
    tick();
    check("t1_rsp_valid",  32'(rsp_valid), 32'h1);
    check("t1_rsp_data",   32'(rsp_data),  32'h46);
    check("t1_rsp_id",     32'(rsp_id),    32'h0);
    check("t1_rsp_busy",   32'(busy),      32'h1);
    check("t1_rsp_op",     32'(alu_op),    32'h0);
    tick();
    check("t1_done_busy",  32'(busy),      32'h0);
    check("t1_done_rv",    32'(rsp_valid), 32'h0);

    // Wrap-around add on requester 2 (rr_ptr is 1).
    set_op(2, 8'hFF, 8'h02);
    req_valid = 3'b100;
    #1;
    check("t2_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    tick();
    check("t2_data", 32'(rsp_data), 32'h01);
    check("t2_id",   32'(rsp_id),   32'h2);
`ifdef ALU_ARB_FLAGS_EN
    check("t2_carry", 32'(rsp_carry), 32'h1);
    check("t2_zero",  32'(rsp_zero),  32'h0);
`endif
    tick();

    set_op(2, 8'h80, 8'h80);
    req_valid = 3'b100;
    #1;
    check("t3_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    tick();
    check("t3_data", 32'(rsp_data), 32'h00);
    check("t3_id",   32'(rsp_id),   32'h2);
`ifdef ALU_ARB_FLAGS_EN
    check("t3_carry", 32'(rsp_carry), 32'h1);
    check("t3_zero",  32'(rsp_zero),  32'h1);
`endif
    tick();

    // Round-robin with all requesters held valid; rr_ptr is 0 here.
    set_op(0, 8'h01, 8'h01);
    set_op(1, 8'h10, 8'h20);
    set_op(2, 8'h05, 8'h07);
    rr_sum[0] = 8'h02;
    rr_sum[1] = 8'h30;
    rr_sum[2] = 8'h0C;
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_ready", 32'(req_ready), 32'(1 << (k % 3)));
      tick();
      check("rr_ready_exec", 32'(req_ready), 32'h0);
      tick();
      check("rr_id",   32'(rsp_id),   32'(k % 3));
      check("rr_data", 32'(rsp_data), 32'(rr_sum[k % 3]));
      tick();
    end
    req_valid = '0;

    // Backpressure; rr_ptr is 0.
    rsp_ready = 1'b0;
    req_valid = 3'b010;
    #1;
    check("bp_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 3'b011;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'h1);
      check("bp_data",  32'(rsp_data),  32'h30);
      check("bp_id",    32'(rsp_id),    32'h1);
      check("bp_ready_hold", 32'(req_ready), 32'h0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_still_valid", 32'(rsp_valid), 32'h1);
    tick();
    check("bp_idle_busy",  32'(busy),      32'h0);
    check("bp_pending",    32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    tick();
    check("bp_next_id",   32'(rsp_id),   32'h0);
    check("bp_next_data", 32'(rsp_data), 32'h02);
    tick();

    // Reset during EXEC; rr_ptr is 1 before it.
    set_op(2, 8'hFF, 8'h02);
    req_valid = 3'b100;
    #1;
    check("rm_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    check("rm_exec_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    tick();
    check("rm_busy",     32'(busy),      32'h0);
    check("rm_rv",       32'(rsp_valid), 32'h0);
    check("rm_alu_a",    32'(alu_a),     32'h0);
    check("rm_alu_op",   32'(alu_op),    32'h0);
    check("rm_rsp_data", 32'(rsp_data),  32'h0);
    rst_n = 1'b1;
    tick();
    check("rm_no_rsp", 32'(rsp_valid), 32'h0);
    req_valid = 3'b111;
    #1;
    check("rm_first_grant", 32'(req_ready), 32'h1);
    tick();
    tick();
    check("rm_first_id", 32'(rsp_id), 32'h0);
    tick();
    check("rm_second_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    tick();
    check("rm_second_id",   32'(rsp_id),   32'h1);
    check("rm_second_data", 32'(rsp_data), 32'h30);
    tick();

    // Request pulsed only during RESP is never granted; rr_ptr is 2.
    req_valid = 3'b001;
    #1;
    check("dr_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    tick();
    req_valid = 3'b010;
    #1;
    check("dr_resp_ready", 32'(req_ready), 32'h0);
    check("dr_resp_id",    32'(rsp_id),    32'h0);
    tick();
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("dr_idle_busy", 32'(busy),      32'h0);
      check("dr_idle_rv",   32'(rsp_valid), 32'h0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
